pwm_bank: RTL and testbench

- Parametrised multi-channel PWM generator; successor to the fixed 3-channel, 2-bit RGB PWM path.
- One shared prescaler and one shared period counter.
- N independent channels, each with a DUTY_WIDTH-bit duty value.
- Duty values are double-buffered, so updates never cause mid-period glitches.
- Sits between switch/register logic and the LED pins; drives RGB and general LEDs in later labs.

---
 rtl/pwm_bank.sv | 120 ++++++++++++
 tb/tb_pwm_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: shared prescaler and period counter, per-channel double-buffered duty.
// Optional `PWM_BANK_BREATHE_EN adds a breathe input that ramps active duties one step per period.

module pwm_bank_lane #(
   parameter int DW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          boundary,
   input  logic          breathe,
   input  logic          duty_load,
   input  logic [DW-1:0] duty_new,
   input  logic [DW-1:0] pwm_cnt,
   output logic          pwm,
   output logic          unsettled
);
   localparam logic [DW-1:0] ONE = 1;

   logic [DW-1:0] shadow, active, target, stepped;

   // target already folds in a same-cycle load, giving the boundary bypass for free
   always_comb begin
      target  = duty_load ? duty_new : shadow;
      stepped = target;
      if (breathe) begin
         if (active < target)      stepped = active + ONE;
         else if (active > target) stepped = active - ONE;
         else                      stepped = active;
      end
      unsettled = (stepped != target);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shadow <= '0;
         active <= '0;
         pwm    <= 1'b0;
      end else begin
         if (duty_load) shadow <= duty_new;
         if (!enable)       active <= target;
         else if (boundary) active <= stepped;
         pwm <= enable && (pwm_cnt < active);
      end
   end
endmodule

module pwm_bank #(
   parameter int CHANNELS        = 3,
   parameter int DUTY_WIDTH      = 8,
   parameter int PRESCALER_WIDTH = 12
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [PRESCALER_WIDTH-1:0]     limit,
   input  logic [CHANNELS*DUTY_WIDTH-1:0] duty_in,
   input  logic                           duty_load,
`ifdef PWM_BANK_BREATHE_EN
   input  logic                           breathe,
`endif
   output logic [CHANNELS-1:0]            pwm,
   output logic                           period_start,
   output logic                           update_pending
);
   localparam logic [PRESCALER_WIDTH-1:0] P_ONE   = 1;
   localparam logic [DUTY_WIDTH-1:0]      D_ONE   = 1;
   localparam logic [DUTY_WIDTH-1:0]      CNT_MAX = '1;

   logic [PRESCALER_WIDTH-1:0] presc_cnt, lim_m1;
   logic [DUTY_WIDTH-1:0]      pwm_cnt;
   logic                       tick, boundary, breathe_en;
   logic [CHANNELS-1:0]        unsettled;

`ifdef PWM_BANK_BREATHE_EN
   assign breathe_en = breathe;
`else
   assign breathe_en = 1'b0;
`endif

   // >= rather than == so a limit shrinking below presc_cnt ticks at once and restarts
   assign lim_m1   = (limit == '0) ? '0 : limit - P_ONE;
   assign tick     = enable && (presc_cnt >= lim_m1);
   assign boundary = tick && (pwm_cnt == CNT_MAX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_cnt      <= '0;
         pwm_cnt        <= '0;
         period_start   <= 1'b0;
         update_pending <= 1'b0;
      end else if (!enable) begin
         presc_cnt      <= '0;
         pwm_cnt        <= '0;
         period_start   <= 1'b0;
         update_pending <= 1'b0;
      end else begin
         presc_cnt    <= tick ? '0 : presc_cnt + P_ONE;
         if (tick) pwm_cnt <= pwm_cnt + D_ONE;
         period_start <= boundary;
         if (boundary)       update_pending <= |unsettled;
         else if (duty_load) update_pending <= 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      pwm_bank_lane #(.DW(DUTY_WIDTH)) u_lane (
         .clock     (clock),
         .reset     (reset),
         .enable    (enable),
         .boundary  (boundary),
         .breathe   (breathe_en),
         .duty_load (duty_load),
         .duty_new  (duty_in[i*DUTY_WIDTH +: DUTY_WIDTH]),
         .pwm_cnt   (pwm_cnt),
         .pwm       (pwm[i]),
         .unsettled (unsettled[i])
      );
   end
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank at CHANNELS=3, DUTY_WIDTH=4, limit=2 (32-clock period).
// Table rows are consecutive periods: an optional mid-period load and the expected high counts.

module tb_pwm_bank;
   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic [11:0] limit;
   logic [11:0] duty_in;
   logic        duty_load;
   logic        breathe;
   logic [2:0]  pwm;
   logic        period_start;
   logic        update_pending;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   pwm_bank #(.CHANNELS(3), .DUTY_WIDTH(4), .PRESCALER_WIDTH(12)) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .limit          (limit),
      .duty_in        (duty_in),
      .duty_load      (duty_load),
`ifdef PWM_BANK_BREATHE_EN
      .breathe        (breathe),
`endif
      .pwm            (pwm),
      .period_start   (period_start),
      .update_pending (update_pending)
   );

   typedef struct {
      string       name;
      int          load_k;
      logic [11:0] duty;
      int          e0, e1, e2, epend;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wait_ps(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!period_start && n < 200);
   endtask

   // Starts on a sample where period_start is high; ends on the next one.
   task automatic run_window(input int load_k, input logic [11:0] d,
                             output int h0, output int h1, output int h2,
                             output int ps, output int pend);
      h0 = 0; h1 = 0; h2 = 0; ps = 0; pend = 0;
      for (int k = 0; k < 32; k++) begin
         h0   += int'(pwm[0]);
         h1   += int'(pwm[1]);
         h2   += int'(pwm[2]);
         ps   += int'(period_start);
         pend += int'(update_pending);
         if (k == load_k) begin
            duty_in   = d;
            duty_load = 1'b1;
         end
         step();
         duty_load = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, h0, h1, h2, ps, pend;

      vt[0] = '{"sweep",        -1, 12'h000, 0, 16, 30,  0};
      vt[1] = '{"simul_load",   31, 12'hF40, 0, 16, 30,  0};
      vt[2] = '{"glitch_load",  12, 12'hFC0, 0,  8, 30, 19};
      vt[3] = '{"after_glitch", -1, 12'h000, 0, 24, 30,  0};
      vt[4] = '{"early_load",    3, 12'h3A1, 0, 24, 30, 28};
      vt[5] = '{"after_early",  -1, 12'h000, 2, 20,  6,  0};

      reset = 1'b0; enable = 1'b0; limit = 12'd2;
      duty_in = '0; duty_load = 1'b0; breathe = 1'b0;
      #2;
      chk("reset_pwm", 32'(pwm), 0);
      chk("reset_ps", 32'(period_start), 0);
      chk("reset_pend", 32'(update_pending), 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      step();

      // load while disabled: active follows shadow, nothing pending
      duty_in = 12'hF80; duty_load = 1'b1;
      step();
      duty_load = 1'b0;
      chk("dis_load_pend", 32'(update_pending), 0);
      enable = 1'b1;
      wait_ps(n);
      chk("first_ps_delay", 32'(n), 32);

      foreach (vt[i]) begin
         run_window(vt[i].load_k, vt[i].duty, h0, h1, h2, ps, pend);
         chk({vt[i].name, "_ch0"}, 32'(h0), 32'(vt[i].e0));
         chk({vt[i].name, "_ch1"}, 32'(h1), 32'(vt[i].e1));
         chk({vt[i].name, "_ch2"}, 32'(h2), 32'(vt[i].e2));
         chk({vt[i].name, "_ps_once"}, 32'(ps), 1);
         chk({vt[i].name, "_ps_next"}, 32'(period_start), 1);
         chk({vt[i].name, "_pend_cycles"}, 32'(pend), 32'(vt[i].epend));
         chk({vt[i].name, "_pend_end"}, 32'(update_pending), 0);
      end

      // reset mid-run with outputs high and a load pending; duties now {1,10,3}
      step(); step();
      duty_in = 12'h555; duty_load = 1'b1;
      step();
      duty_load = 1'b0;
      chk("pre_reset_pwm", 32'(pwm), 32'b110);
      chk("pre_reset_pend", 32'(update_pending), 1);
      reset = 1'b0;
      #1;
      chk("async_reset_pwm", 32'(pwm), 0);
      chk("async_reset_pend", 32'(update_pending), 0);
      chk("async_reset_ps", 32'(period_start), 0);
      enable = 1'b0;
      step();
      reset = 1'b1;
      step();

      // limit 0 and limit 1 both tick every clock
      limit = 12'd0; enable = 1'b1;
      wait_ps(n);
      chk("limit0_first", 32'(n), 16);
      wait_ps(n);
      chk("limit0_period", 32'(n), 16);
      enable = 1'b0; limit = 12'd1;
      step();
      enable = 1'b1;
      wait_ps(n);
      chk("limit1_first", 32'(n), 16);
      wait_ps(n);
      chk("limit1_period", 32'(n), 16);

      // enable gating
      enable = 1'b0; limit = 12'd2;
      duty_in = 12'hF80; duty_load = 1'b1;
      step();
      duty_load = 1'b0;
      enable = 1'b1;
      wait_ps(n);
      chk("gate_ps_delay", 32'(n), 32);
      step(); step(); step(); step();
      chk("gate_pwm_running", 32'(pwm), 32'b110);
      enable = 1'b0;
      step();
      chk("gate_pwm_off", 32'(pwm), 0);
      chk("gate_ps_off", 32'(period_start), 0);
      duty_in = 12'h001; duty_load = 1'b1;
      step();
      duty_load = 1'b0;
      chk("gate_load_pend", 32'(update_pending), 0);
      enable = 1'b1;
      wait_ps(n);
      chk("reenable_ps_delay", 32'(n), 32);

      // limit 100 -> 5 with presc_cnt at 50: tick right away (ch0 duty 1 shows pwm_cnt leaving 0)
      enable = 1'b0; limit = 12'd100;
      step();
      enable = 1'b1;
      for (int i = 0; i < 50; i++) step();
      chk("presc50_pwm0", 32'(pwm[0]), 1);
      limit = 12'd5;
      step();
      chk("limit_shrink_lag", 32'(pwm[0]), 1);
      step();
      chk("limit_shrink_tick", 32'(pwm[0]), 0);

`ifdef PWM_BANK_BREATHE_EN
      // ch0 ramps 0 -> 3 over three boundaries
      enable = 1'b0; limit = 12'd2;
      duty_in = 12'h000; duty_load = 1'b1;
      step();
      duty_load = 1'b0;
      enable = 1'b1; breathe = 1'b1;
      wait_ps(n);
      duty_in = 12'h003; duty_load = 1'b1;
      step();
      duty_load = 1'b0;
      for (int b = 1; b <= 3; b++) begin
         wait_ps(n);
         chk("breathe_pend", 32'(update_pending), (b < 3) ? 32'd1 : 32'd0);
      end
      run_window(-1, 12'h000, h0, h1, h2, ps, pend);
      chk("breathe_final_ch0", 32'(h0), 6);
      breathe = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
